// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, flag positions and FSM states shared by the multicycle ALU
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [5:0] c_op_add  = 6'h00;
    localparam logic [5:0] c_op_sub  = 6'h01;
    localparam logic [5:0] c_op_and  = 6'h02;
    localparam logic [5:0] c_op_or   = 6'h03;
    localparam logic [5:0] c_op_xor  = 6'h04;
    localparam logic [5:0] c_op_not  = 6'h05;
    localparam logic [5:0] c_op_shl  = 6'h06;
    localparam logic [5:0] c_op_shr  = 6'h07;
    localparam logic [5:0] c_op_mul  = 6'h08;
    localparam logic [5:0] c_op_div  = 6'h09;
    localparam logic [5:0] c_op_mod  = 6'h0A;
    localparam logic [5:0] c_op_cmp  = 6'h0B;
    localparam logic [5:0] c_op_sar  = 6'h0C;
    localparam logic [5:0] c_op_addi = 6'h0D;
    localparam logic [5:0] c_op_subi = 6'h0E;
    localparam logic [5:0] c_op_mulh = 6'h0F;
    localparam logic [5:0] c_op_divs = 6'h10;
    localparam logic [5:0] c_op_mods = 6'h11;

    localparam int c_flag_c = 0;
    localparam int c_flag_z = 1;
    localparam int c_flag_n = 2;
    localparam int c_flag_v = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == c_op_mul) || (op == c_op_mulh);
    endfunction

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == c_op_div) || (op == c_op_mod) ||
               (op == c_op_divs) || (op == c_op_mods);
    endfunction

    function automatic logic is_sdiv_op(input logic [5:0] op);
        return (op == c_op_divs) || (op == c_op_mods);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter_divider
// Brief    : Unsigned restoring divider, one quotient bit per cycle
// Revision : 1.0
// ============================================================================
module alu_iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dsor_q, dsor_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               run_q, run_d;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;

    // Partial remainder gains the next dividend bit; keep it only if no borrow
    assign w_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, dsor_q};

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dsor_d = dsor_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dsor_d = divisor;
            cnt_d  = c_cnt_w'(WIDTH);
            run_d  = 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - c_cnt_w'(1);
                if (w_trial[WIDTH]) begin
                    rem_d = w_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = w_trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsor_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsor_q <= dsor_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

    assign done      = run_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Brief    : Registered ALU with iterative multiply/divide behind valid/ready
// Revision : 1.0
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH    = 32,
    parameter int FAST_MUL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [7:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [7:0]       out_flags,
    output logic             busy
);

    import alu_pkg::*;

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam int c_sh_w  = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         fl_hi_q, fl_hi_d;
    logic               cin_q, cin_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [2*WIDTH:0]   mprod_q, mprod_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [7:0]         flags_q, flags_d;

    logic               w_accept;
    logic               w_in_iter;
    logic               w_in_neg_a;
    logic               w_in_neg_b;
    logic [WIDTH-1:0]   w_dvd;
    logic [WIDTH-1:0]   w_dsor;
    logic               w_div_start;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_iter_last;
    logic               w_unused_flags;

    logic [WIDTH:0]     w_mul_add;
    logic [2*WIDTH:0]   w_mul_step;
    logic [2*WIDTH-1:0] w_prod;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [c_sh_w-1:0]  w_amt;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic signed [WIDTH:0] w_sar_src;
    logic signed [WIDTH:0] w_sar;
    logic               w_min_neg1;
    logic               w_v_add;
    logic               w_v_sub;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;

    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [7:0]         w_flags;

    assign w_accept       = in_valid && (state_q == ST_IDLE);
    assign w_in_iter      = (is_mul_op(in_op) && (FAST_MUL == 0)) ||
                            (is_div_op(in_op) && (in_b != '0));
    assign w_unused_flags = ^in_flags[3:1];

    // Signed divides run on magnitudes; the sign is restored on completion
    assign w_in_neg_a  = is_sdiv_op(in_op) && in_a[WIDTH-1];
    assign w_in_neg_b  = is_sdiv_op(in_op) && in_b[WIDTH-1];
    assign w_dvd       = w_in_neg_a ? -in_a : in_a;
    assign w_dsor      = w_in_neg_b ? -in_b : in_b;
    assign w_div_start = w_accept && is_div_op(in_op) && (in_b != '0);

    alu_iter_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (w_dvd),
        .divisor   (w_dsor),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    assign w_iter_last = is_div_op(op_q) ? w_div_done : (cnt_q == '0);

    // Shift-add: {hi, lo} starts as {0, b}; add a into hi on lo[0], shift right
    assign w_mul_add  = mprod_q[2*WIDTH:WIDTH] + (mprod_q[0] ? {1'b0, a_q} : '0);
    assign w_mul_step = {1'b0, w_mul_add, mprod_q[WIDTH-1:1]};

    if (FAST_MUL != 0) begin : g_fast_mul
        assign w_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    end else begin : g_iter_mul
        assign w_prod = mprod_q[2*WIDTH-1:0];
    end

    assign w_sum      = {1'b0, a_q} + {1'b0, b_q};
    assign w_diff     = {1'b0, a_q} - {1'b0, b_q};
    assign w_v_add    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_sum[WIDTH-1] != a_q[WIDTH-1]);
    assign w_v_sub    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (w_diff[WIDTH-1] != a_q[WIDTH-1]);
    assign w_amt      = b_q[c_sh_w-1:0];
    assign w_shl      = {1'b0, a_q} << w_amt;
    assign w_shr      = {a_q, 1'b0} >> w_amt;
    assign w_sar_src  = {a_q, 1'b0};
    assign w_sar      = w_sar_src >>> w_amt;
    assign w_min_neg1 = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
    assign w_quo_s    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -w_div_quo : w_div_quo;
    assign w_rem_s    = a_q[WIDTH-1] ? -w_div_rem : w_div_rem;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (op_q)
            c_op_add, c_op_addi: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_v_add;
            end
            c_op_sub, c_op_subi: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = w_v_sub;
            end
            c_op_cmp: begin
                w_res = a_q;
                w_c   = w_diff[WIDTH];
                w_v   = w_v_sub;
            end
            c_op_and: w_res = a_q & b_q;
            c_op_or:  w_res = a_q | b_q;
            c_op_xor: w_res = a_q ^ b_q;
            c_op_not: w_res = ~a_q;
            c_op_shl: begin
                {w_c, w_res} = w_shl;
                if (w_amt == '0) w_c = cin_q;
            end
            c_op_shr: begin
                {w_res, w_c} = w_shr;
                if (w_amt == '0) w_c = cin_q;
            end
            c_op_sar: begin
                {w_res, w_c} = w_sar;
                if (w_amt == '0) w_c = cin_q;
            end
            c_op_mul: begin
                w_res = w_prod[WIDTH-1:0];
                w_v   = |w_prod[2*WIDTH-1:WIDTH];
            end
            c_op_mulh: begin
                w_res = w_prod[2*WIDTH-1:WIDTH];
                w_v   = |w_prod[2*WIDTH-1:WIDTH];
            end
            c_op_div, c_op_divs: begin
                if (b_q == '0) begin
                    w_res = '1;
                    w_c   = 1'b1;
                end else if (op_q == c_op_div) begin
                    w_res = w_div_quo;
                end else begin
                    w_res = w_quo_s;
                    w_v   = w_min_neg1;
                end
            end
            c_op_mod, c_op_mods: begin
                if (b_q == '0) begin
                    w_c = 1'b1;
                end else if (op_q == c_op_mod) begin
                    w_res = w_div_rem;
                end else begin
                    w_res = w_rem_s;
                    w_v   = w_min_neg1;
                end
            end
            default: begin
                w_res = '0;
            end
        endcase
    end

    always_comb begin
        w_flags           = {fl_hi_q, 4'b0000};
        w_flags[c_flag_c] = w_c;
        w_flags[c_flag_z] = (w_res == '0);
        w_flags[c_flag_n] = w_res[WIDTH-1];
        w_flags[c_flag_v] = w_v;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        fl_hi_d = fl_hi_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        mprod_d = mprod_q;
        res_d   = res_q;
        flags_d = flags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    fl_hi_d = in_flags[7:4];
                    cin_d   = in_flags[c_flag_c];
                    cnt_d   = c_cnt_w'(WIDTH);
                    mprod_d = {{(WIDTH+1){1'b0}}, in_b};
                    state_d = w_in_iter ? ST_ITER : ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = w_res;
                flags_d = w_flags;
                state_d = ST_DONE;
            end
            ST_ITER: begin
                if (w_iter_last) begin
                    res_d   = w_res;
                    flags_d = w_flags;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - c_cnt_w'(1);
                    mprod_d = w_mul_step;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fl_hi_q <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            mprod_q <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fl_hi_q <= fl_hi_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            mprod_q <= mprod_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q == ST_ITER);
    assign out_result = res_q;
    assign out_flags  = flags_q;

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the core combinational ALU.
- Single-cycle ops complete in 1 cycle. MUL/DIV/MOD families run on an iterative shift-add multiplier and restoring divider, which removes the combinational multiply/divide from the execute critical path.
- Adds signed divide/modulo, high-half multiply and true variable shift amounts.
- Sits in the CPU execute stage behind a valid/ready handshake; the core stalls while in_ready is low.

Parameters:
- WIDTH, 32, operand/result width (power of 2, >=8)
- FAST_MUL, 0, 1 = MUL/MULH use a single-cycle combinational multiply (latency 1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block accepts a request this cycle
- in_op  in  6  opcode
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_flags  in  8  incoming flags
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_flags  out  8  flags
- busy  out  1  iterative op in progress

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE, out_valid=0, out_result=0, out_flags=0, busy=0, in_ready=1 in the first cycle after reset. Reset mid-operation aborts; the partial result is discarded.
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 NOT
  - 0x06 SHL, 0x07 SHR, 0x08 MUL, 0x09 DIV, 0x0A MOD, 0x0B CMP
  - 0x0C SAR, 0x0D ADDI, 0x0E SUBI
  - new: 0x0F MULH, 0x10 DIVS, 0x11 MODS
  - others give result 0, carry 0.
- Flags: bit0 carry, bit1 zero, bit2 negative, bit3 overflow. Bits 7:4 pass through from the captured in_flags. Zero = (result==0) and negative = result[WIDTH-1] for every op.
- Handshake: in_ready = (state==IDLE). A request is accepted on in_valid&&in_ready, and operands, op and flags are captured. out_valid holds with stable outputs until out_valid&&out_ready, then returns to IDLE. There is no accept in the cycle of output retirement.
- FSM: IDLE -> EXEC (single-cycle ops, FAST_MUL muls, divide-by-zero) or ITER (iterative ops).
  - EXEC -> DONE next cycle.
  - ITER counts WIDTH cycles, then -> DONE.
  - Latency from accept to out_valid: 1 cycle single-cycle, WIDTH+1 cycles iterative.
  - busy=1 only in ITER.
- ADD/ADDI/SUB/SUBI:
  - carry = bit WIDTH of the (WIDTH+1)-bit sum/difference.
  - ADD/ADDI overflow = operands same sign and result sign differs.
  - SUB/SUBI overflow = operand signs differ and result sign differs from a.
- CMP: result=a; carry=borrow of a-b; overflow as SUB.
- Logic ops: carry=0.
- Shifts use amount = b[log2(WIDTH)-1:0].
  - carry = last bit shifted out.
  - amount 0 -> result=a, carry=in_flags carry.
  - SAR sign-fills.
- MUL: low WIDTH bits of the unsigned product. MULH: high WIDTH bits. Both: carry=0, overflow = (high half != 0).
- DIV/MOD: unsigned.
- DIVS/MODS:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/-1 -> DIVS=MIN, MODS=0, overflow=1.
- Divide by zero (all four): latency 1; DIV/DIVS=all-ones, MOD/MODS=0, carry=1.
- An in_valid arriving while not ready is ignored; the requester holds it.

Decomposition:
- Shared package alu_pkg: opcode localparams, flag bit positions, FSM state encoding.
- One sub-module alu_iter_divider: unsigned restoring divider, start/done, WIDTH cycles. The top handles sign conversion around it.
- The shift-add multiplier stays inline.

Test Plan:
- ADD 0xFFFFFFFF + 1, in_flags=0xA0 -> 1 cycle later out_result=0, out_flags=0xA3 (carry, zero, upper nibble kept).
- MUL 0x00010000 * 0x00010000 (FAST_MUL=0) -> out_valid exactly 33 cycles after accept, result 0, overflow=1, zero=1; MULH same operands -> result 1.
- DIVS -7 / 2 -> 0xFFFFFFFD; MODS -7 % 2 -> 0xFFFFFFFF; DIVS 0x80000000 / -1 -> 0x80000000, overflow=1.
- DIV 5 / 0 -> latency 1, result 0xFFFFFFFF, carry=1; MOD 5 / 0 -> 0, carry=1, zero=1.
- SHL 0x80000001 by 1 -> 0x00000002, carry=1; SAR 0x80000000 by 4 -> 0xF8000000; SHR by 0 with carry-in 1 -> result a, carry=1.
- Back-pressure: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Assert rst during ITER of a DIV -> next cycle out_valid=0, busy=0, in_ready=1, and a following ADD 2+3 returns 5.
